// File: rtl/tick_pkg.sv
// rtl/tick_pkg.sv - shared constants, ratio type and ratio clamp for tick_generator
// Purpose : common definitions for the tick_generator block.
// Contents: WIDTH_DEFAULT  - default ratio/counter width
//           DEFAULT_RATIO  - ratio every channel runs at after reset
//           ratio_t        - ratio/counter word at the default width
//           sat_ratio      - clamps a requested ratio to >= 1 (0 maps to 1)
package tick_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int DEFAULT_RATIO = 100;

  typedef logic [WIDTH_DEFAULT-1:0] ratio_t;

  // Operates on a 32-bit word so that channels of any width up to 32 bits can
  // share it; callers zero-extend in and truncate back out.
  function automatic logic [31:0] sat_ratio(input logic [31:0] r);
    return (r == 32'd0) ? 32'd1 : r;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// rtl/tick_channel.sv - one divider channel: counter, active/shadow ratio, tick and slow clock
// Purpose : divides clk by a runtime ratio, producing a one-cycle tick and a
//           ~50% duty level. New ratios land in a shadow register and only
//           take effect at a wrap or a sync, so a period is never cut short.
// Ports   : clk_i, rst_ni    - clock, asynchronous active-low reset
//           enable_i         - run; low freezes count and active ratio
//           sync_i           - restart at count 0 (wins over wrap/increment)
//           load_i, ratio_i  - capture max(ratio_i,1) into the shadow
//           tick_o           - high in the last cycle of each period
//           slow_clock_o     - high for the first ceil(R/2) cycles of a period
module tick_channel
  import tick_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int RESET_RATIO = DEFAULT_RATIO
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             sync_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] ratio_i,
  output logic             tick_o,
  output logic             slow_clock_o
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_RATE = WIDTH'(RESET_RATIO);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] next_ratio;
  logic             at_last;

  assign load_val = WIDTH'(sat_ratio(32'(ratio_i)));

  // A load in the same cycle as a wrap/sync bypasses the shadow so the new
  // value governs the very next period.
  assign next_ratio = load_i ? load_val : shadow_q;

  // active is always >= 1, so active-1 never underflows and count never
  // passes it.
  assign at_last = (count_q == (active_q - ONE));

  always_comb begin
    count_d  = count_q;
    active_d = active_q;
    shadow_d = load_i ? load_val : shadow_q;
    if (sync_i) begin
      count_d  = '0;
      active_d = next_ratio;
    end else if (enable_i) begin
      if (at_last) begin
        count_d  = '0;
        active_d = next_ratio;
      end else begin
        count_d = count_q + ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      active_q <= RST_RATE;
      shadow_q <= RST_RATE;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
    end
  end

  assign tick_o = enable_i & ~sync_i & at_last;

  // High threshold is active - floor(active/2) = ceil(active/2): odd ratios
  // spend the extra cycle high, and a ratio of 1 stays high permanently.
  assign slow_clock_o = (count_q < (active_q - (active_q >> 1)));

endmodule

// File: rtl/tick_generator.sv
// rtl/tick_generator.sv - multi-channel programmable clock-enable generator (top)
// Purpose : CHANNELS independent dividers in the clk domain sharing enable,
//           sync and ratio_in; each has its own load strobe.
// Ports   : clk, n_reset      - clock, asynchronous active-low reset
//           enable            - global run
//           sync              - restart all channels at count 0
//           load[CHANNELS]    - per-channel shadow capture strobe
//           ratio_in[WIDTH]   - shared ratio value (0 treated as 1)
//           tick[CHANNELS]    - one-cycle enable per period
//           slow_clock[CHANNELS] - divided level outputs
// WIDTH may be 1..32.
module tick_generator #(
  parameter int CHANNELS      = 4,
  parameter int WIDTH         = tick_pkg::WIDTH_DEFAULT,
  parameter int DEFAULT_RATIO = tick_pkg::DEFAULT_RATIO
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                enable,
  input  logic                sync,
  input  logic [CHANNELS-1:0] load,
  input  logic [WIDTH-1:0]    ratio_in,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] slow_clock
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    tick_channel #(
      .WIDTH       (WIDTH),
      .RESET_RATIO (DEFAULT_RATIO)
    ) u_ch (
      .clk_i        (clk),
      .rst_ni       (n_reset),
      .enable_i     (enable),
      .sync_i       (sync),
      .load_i       (load[i]),
      .ratio_i      (ratio_in),
      .tick_o       (tick[i]),
      .slow_clock_o (slow_clock[i])
    );
  end

endmodule
